// File: rtl/rggen_rtl_pkg.sv
// Shared types and helpers for the generic bit-field storage element.
package rggen_rtl_pkg;

  typedef enum logic [2:0] {
    RGGEN_RW,
    RGGEN_RO,
    RGGEN_RC,
    RGGEN_RS,
    RGGEN_W1C,
    RGGEN_W1S,
    RGGEN_W1T,
    RGGEN_WO
  } rggen_bit_field_mode_e;

  // Per-bit SW next value. The write op is applied first, then any RC/RS read op overrides it.
  // wr/rd are the effective strobes after lock, write-once and mask qualification.
  function automatic logic rggen_sw_next(
    input rggen_bit_field_mode_e mode,
    input logic                  v,
    input logic                  d,
    input logic                  m,
    input logic                  rd,
    input logic                  wr
  );
    logic n;
    n = v;
    case (mode)
      RGGEN_RW, RGGEN_WO: if (wr && m) n = d;
      RGGEN_W1C:          if (wr && m && d) n = 1'b0;
      RGGEN_W1S:          if (wr && m && d) n = 1'b1;
      RGGEN_W1T:          n = wr & m & d;  // self-clearing when no write-1 is present
      RGGEN_RC:           if (rd) n = 1'b0;
      RGGEN_RS:           if (rd) n = 1'b1;
      default:            n = v;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rggen_bit_field_generic_if.sv
// Register-bus side of one bit field: SW access strobes, write data/mask, read data and triggers.
interface rggen_bit_field_generic_if #(
  parameter int unsigned WIDTH = 8
);

  logic             i_read_access;
  logic             i_write_access;
  logic [WIDTH-1:0] i_write_data;
  logic [WIDTH-1:0] i_write_mask;
  logic             i_sw_write_enable;
  logic [WIDTH-1:0] o_read_data;
  logic             o_write_trigger;
  logic             o_read_trigger;

  modport master (
    output i_read_access,
    output i_write_access,
    output i_write_data,
    output i_write_mask,
    output i_sw_write_enable,
    input  o_read_data,
    input  o_write_trigger,
    input  o_read_trigger
  );

  modport slave (
    input  i_read_access,
    input  i_write_access,
    input  i_write_data,
    input  i_write_mask,
    input  i_sw_write_enable,
    output o_read_data,
    output o_write_trigger,
    output o_read_trigger
  );

endinterface

// File: rtl/rggen_bit_field_generic.sv
// Storage element behind one register bit field: SW access per MODE on the bus side,
// HW clear/set/load on the logic side, with write lock/once control and access triggers.
module rggen_bit_field_generic
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned          WIDTH         = 8,
  parameter logic [WIDTH-1:0]     INITIAL_VALUE = '0,
  parameter rggen_bit_field_mode_e MODE         = RGGEN_RW,
  parameter bit                   SW_WRITE_ONCE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rggen_bit_field_generic_if.slave bus_if,
  input  logic [WIDTH-1:0]         i_hw_set,
  input  logic [WIDTH-1:0]         i_hw_clear,
  input  logic                     i_hw_write_enable,
  input  logic [WIDTH-1:0]         i_hw_write_data,
  output logic [WIDTH-1:0]         o_value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             write_trigger_q;
  logic             read_trigger_q;
  logic             once_q;
  logic             sw_write;
  logic             sw_read;

  // Qualify SW strobes; a blocked or all-masked write is not a write at all.
  always_comb begin
    sw_write = bus_if.i_write_access & bus_if.i_sw_write_enable & ~once_q &
               (|bus_if.i_write_mask);
    sw_read  = bus_if.i_read_access;
  end

  // Next value: SW op, then HW clear, HW set, HW load in rising priority.
  always_comb begin
    value_d = value_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      value_d[i] = rggen_sw_next(MODE, value_q[i], bus_if.i_write_data[i],
                                 bus_if.i_write_mask[i], sw_read, sw_write);
    end
    value_d = value_d & ~i_hw_clear;
    value_d = value_d | i_hw_set;
    if (i_hw_write_enable) begin
      value_d = i_hw_write_data;
    end
  end

  // Field value register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= INITIAL_VALUE;
    end else begin
      value_q <= value_d;
    end
  end

  // One-cycle access trigger pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_trigger_q <= 1'b0;
      read_trigger_q  <= 1'b0;
    end else begin
      write_trigger_q <= sw_write;
      read_trigger_q  <= sw_read;
    end
  end

  if (SW_WRITE_ONCE) begin : g_once
    // Latches after the first effective SW write; only reset reopens the field.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        once_q <= 1'b0;
      end else if (sw_write) begin
        once_q <= 1'b1;
      end
    end
  end else begin : g_no_once
    assign once_q = 1'b0;
  end

  if (MODE == RGGEN_WO) begin : g_rd_zero
    assign bus_if.o_read_data = '0;
  end else begin : g_rd_value
    assign bus_if.o_read_data = value_q;
  end

  assign bus_if.o_write_trigger = write_trigger_q;
  assign bus_if.o_read_trigger  = read_trigger_q;
  assign o_value                = value_q;

endmodule
